twos_comp_serial_ctrl: RTL and testbench



---
 rtl/twos_comp_serial_ctrl_pkg.sv | 13 +
 rtl/twos_comp_serial_ctrl_if.sv | 29 ++
 rtl/twos_comp_serial_ctrl_bit_cell.sv | 30 +++
 rtl/twos_comp_serial_ctrl.sv | 130 +++++++++++++
 tb/tb_twos_comp_serial_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/twos_comp_serial_ctrl_pkg.sv
// Shared types and constants for the serial two's-complement controller.
// Holds the controller state encoding and the default word width.
package tc_ctrl_pkg;

    localparam int unsigned TC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : tc_ctrl_pkg

// File: rtl/twos_comp_serial_ctrl_if.sv
// Producer/consumer handshake bundle for the serial two's-complement controller.
// The controller side uses the slave modport; the environment uses master.
interface twos_comp_serial_ctrl_if
    import tc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = TC_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_data, in_neg, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, in_neg, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );

endinterface : twos_comp_serial_ctrl_if

// File: rtl/twos_comp_serial_ctrl_bit_cell.sv
// Mealy serial two's-complement cell: copies bits up to and including the
// first 1, then inverts every later bit when neg is set.
module tc_bit_cell (
    input  logic t_clk,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic b,
    output logic y
);

    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clr) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | b;
        end
    end

    always_ff @(posedge t_clk) begin
        seen_one_q <= seen_one_d;
    end

    assign y = neg ? (b ^ seen_one_q) : b;

endmodule : tc_bit_cell

// File: rtl/twos_comp_serial_ctrl.sv
// Accepts a parallel word, streams it LSB-first through tc_bit_cell, and
// returns the reassembled result plus a most-negative overflow flag.
module twos_comp_serial_ctrl
    import tc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = TC_WIDTH
) (
    input  logic                    t_clk,
    input  logic                    r,
    twos_comp_serial_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             neg_q,       neg_d;
    logic             ovf_track_q, ovf_track_d;
    logic             out_ovf_q,   out_ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic             accept_c;
    logic             shift_en_c;
    logic             clr_c;
    logic             bit_y_c;

    // Cell restarts on every accepted word and on reset.
    assign clr_c = r | accept_c;

    tc_bit_cell u_bit_cell (
        .t_clk (t_clk),
        .clr   (clr_c),
        .en    (shift_en_c),
        .neg   (neg_q),
        .b     (sr_q[0]),
        .y     (bit_y_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        ovf_track_d = ovf_track_q;
        out_ovf_d   = out_ovf_q;
        accept_c    = 1'b0;
        shift_en_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept_c    = 1'b1;
                    sr_d        = bus.in_data;
                    neg_d       = bus.in_neg;
                    cnt_d       = '0;
                    ovf_track_d = 1'b1;
                    state_d     = SHIFT;
                end
            end

            SHIFT: begin
                shift_en_c = 1'b1;
                res_d      = {bit_y_c, res_q[WIDTH-1:1]};
                sr_d       = sr_q >> 1;
                cnt_d      = CNT_W'(cnt_q + 1'b1);
                // Overflow only if every bit below the MSB was 0 and the MSB is 1.
                if (cnt_q == CNT_LAST) begin
                    out_ovf_d = neg_q & ovf_track_q & sr_q[0];
                    state_d   = DONE;
                end else begin
                    ovf_track_d = ovf_track_q & ~sr_q[0];
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            ovf_track_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            ovf_track_q <= ovf_track_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.busy      = busy_q;

endmodule : twos_comp_serial_ctrl

// File: tb/tb_twos_comp_serial_ctrl.sv
// Directed self-checking bench for twos_comp_serial_ctrl (WIDTH=8).
module tb_twos_comp_serial_ctrl;

    localparam int unsigned W = 8;
    localparam int BUDGET = 100;

    logic clk;
    logic r;
    int   n_cmp  = 0;
    int   n_fail = 0;

    twos_comp_serial_ctrl_if #(.WIDTH(W)) bus ();

    twos_comp_serial_ctrl #(.WIDTH(W)) dut (
        .t_clk (clk),
        .r     (r),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word and returns once the accept edge has passed.
    task automatic send_word(input logic [W-1:0] d, input logic n, output bit to);
        int k;
        k  = 0;
        to = 1'b0;
        bus.in_data  = d;
        bus.in_neg   = n;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && k < BUDGET) begin
            tick();
            k++;
        end
        if (k >= BUDGET) to = 1'b1;
        else tick();
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_neg   = 1'($urandom);
    endtask

    // Waits for a result, stalls the consumer, then takes it.
    task automatic recv_word(input int stall, output logic [W-1:0] d, output logic o, output bit to);
        int k;
        k  = 0;
        to = 1'b0;
        d  = '0;
        o  = 1'b0;
        bus.out_ready = 1'b0;
        while (bus.out_valid !== 1'b1 && k < BUDGET) begin
            tick();
            k++;
        end
        if (k >= BUDGET) begin
            to = 1'b1;
        end else begin
            repeat (stall) tick();
            d = bus.out_data;
            o = bus.out_ovf;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        r = 1'b1;
        tick();
        tick();
        r = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++;
        if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        n_cmp++;
        if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got=%b exp=0", bus.out_ovf); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    endtask

    // 0x05 negated: first valid exactly 8 edges after accept, in_ready low 9 samples.
    task automatic test_latency();
        int first_valid;
        int low_cnt;
        logic [W-1:0] d_at_valid;
        logic o_at_valid;
        logic busy_at_valid;
        first_valid   = -1;
        low_cnt       = 0;
        d_at_valid    = '0;
        o_at_valid    = 1'b0;
        busy_at_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data   = 8'h05;
        bus.in_neg    = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hFF;
        bus.in_neg   = 1'b0;
        if (bus.in_ready === 1'b0) low_cnt++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.in_ready === 1'b0) low_cnt++;
            if (bus.out_valid === 1'b1 && first_valid < 0) begin
                first_valid   = k;
                d_at_valid    = bus.out_data;
                o_at_valid    = bus.out_ovf;
                busy_at_valid = bus.busy;
            end
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (first_valid !== 8) begin n_fail++; $display("FAIL lat_first_valid got=%0d exp=8", first_valid); end
        n_cmp++;
        if (low_cnt !== 9) begin n_fail++; $display("FAIL lat_in_ready_low got=%0d exp=9", low_cnt); end
        n_cmp++;
        if (d_at_valid !== 8'hFB) begin n_fail++; $display("FAIL lat_data got=%h exp=fb", d_at_valid); end
        n_cmp++;
        if (o_at_valid !== 1'b0) begin n_fail++; $display("FAIL lat_ovf got=%b exp=0", o_at_valid); end
        n_cmp++;
        if (busy_at_valid !== 1'b1) begin n_fail++; $display("FAIL lat_busy got=%b exp=1", busy_at_valid); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] vin [5]  = '{8'h00, 8'h80, 8'h7F, 8'h5A, 8'h5A};
        logic         vneg[5]  = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [W-1:0] vexp[5]  = '{8'h00, 8'h80, 8'h81, 8'h5A, 8'hA6};
        logic         vovf[5]  = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        logic [W-1:0] d;
        logic o;
        bit to_s, to_r;
        for (int i = 0; i < 5; i++) begin
            send_word(vin[i], vneg[i], to_s);
            recv_word(i, d, o, to_r);
            n_cmp++;
            if ((to_s | to_r) !== 1'b0) begin n_fail++; $display("FAIL vec%0d_timeout got=%b exp=0", i, to_s | to_r); end
            n_cmp++;
            if (d !== vexp[i]) begin n_fail++; $display("FAIL vec%0d_data in=%h neg=%b got=%h exp=%h", i, vin[i], vneg[i], d, vexp[i]); end
            n_cmp++;
            if (o !== vovf[i]) begin n_fail++; $display("FAIL vec%0d_ovf in=%h neg=%b got=%b exp=%b", i, vin[i], vneg[i], o, vovf[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int k;
        logic [W-1:0] d;
        logic o;
        bus.out_ready = 1'b0;
        send_word(8'h05, 1'b1, to);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < BUDGET) begin tick(); k++; end
        n_cmp++;
        if (to || k >= BUDGET) begin n_fail++; $display("FAIL bp_wait_valid got=timeout exp=valid"); end
        bus.in_data  = 8'h7F;
        bus.in_neg   = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (bus.out_data !== 8'hFB || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d data got=%h/%b exp=fb/1", c, bus.out_data, bus.out_valid);
            end
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got=%b exp=0", c, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_after_hs valid/ready/busy got=%b%b%b exp=010", bus.out_valid, bus.in_ready, bus.busy);
        end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_second_accept ready/busy got=%b%b exp=01", bus.in_ready, bus.busy);
        end
        recv_word(0, d, o, to);
        n_cmp++;
        if (to || d !== 8'h81 || o !== 1'b0) begin
            n_fail++; $display("FAIL bp_second_word got=%h/%b exp=81/0", d, o);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int k;
        logic [W-1:0] d;
        logic o;
        bus.out_ready = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            send_word(8'hF0, 1'b1, to);
            repeat (pass == 0 ? 3 : 6) tick();
            r = 1'b1;
            tick();
            r = 1'b0;
            n_cmp++;
            if (to || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL rst_shift%0d ready/valid/busy got=%b%b%b exp=100", pass, bus.in_ready, bus.out_valid, bus.busy);
            end
        end
        send_word(8'h01, 1'b1, to);
        recv_word(0, d, o, to);
        n_cmp++;
        if (to || d !== 8'hFF || o !== 1'b0) begin n_fail++; $display("FAIL rst_then_01 got=%h/%b exp=ff/0", d, o); end
        send_word(8'h05, 1'b1, to);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < BUDGET) begin tick(); k++; end
        tick();
        r = 1'b1;
        tick();
        r = 1'b0;
        n_cmp++;
        if (k >= BUDGET || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_done valid/ready got=%b%b exp=01", bus.out_valid, bus.in_ready);
        end
        send_word(8'h02, 1'b1, to);
        recv_word(1, d, o, to);
        n_cmp++;
        if (to || d !== 8'hFE || o !== 1'b0) begin n_fail++; $display("FAIL rst_then_02 got=%h/%b exp=fe/0", d, o); end
    endtask

    task automatic test_all_values();
        logic [W-1:0] x;
        logic [W-1:0] exp_d;
        logic exp_o;
        logic n;
        logic [W-1:0] d;
        logic o;
        bit to_s, to_r;
        for (int i = 0; i < 256; i++) begin
            x = W'(i);
            n = 1'($urandom_range(0, 1));
            exp_d = n ? W'(~x + 8'd1) : x;
            exp_o = n && (x == 8'h80);
            repeat ($urandom_range(0, 2)) tick();
            send_word(x, n, to_s);
            recv_word($urandom_range(0, 3), d, o, to_r);
            n_cmp++;
            if (to_s || to_r || d !== exp_d) begin n_fail++; $display("FAIL all_data x=%h neg=%b got=%h exp=%h", x, n, d, exp_d); end
            n_cmp++;
            if (o !== exp_o) begin n_fail++; $display("FAIL all_ovf x=%h neg=%b got=%b exp=%b", x, n, o, exp_o); end
        end
    endtask

    initial begin
        r             = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_neg    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_all_values();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_twos_comp_serial_ctrl
